// File: rtl/mips32_pkg.sv
//------------------------------------------------------------------------------
// mips32_pkg : shared control-bit indices, MEM-stage FSM encoding, defaults
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips32_pkg;

  localparam int CTL_MEMREAD  = 3;
  localparam int CTL_MEMWRITE = 2;
  localparam int CTL_REGWRITE = 1;
  localparam int CTL_MEMTOREG = 0;

  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
//------------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register with load enable and async reset
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [1:0]  i_ctrl,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_mem,
  input  logic [4:0]  i_dest,
  output logic [1:0]  o_ctrl,
  output logic [31:0] o_pc,
  output logic [31:0] o_alu,
  output logic [31:0] o_mem,
  output logic [4:0]  o_dest
);

  logic [1:0]  r_ctrl;
  logic [31:0] r_pc;
  logic [31:0] r_alu;
  logic [31:0] r_mem;
  logic [4:0]  r_dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= 2'b00;
      r_pc   <= 32'h0;
      r_alu  <= 32'h0;
      r_mem  <= 32'h0;
      r_dest <= 5'd0;
    end else if (i_en) begin
      r_ctrl <= i_ctrl;
      r_pc   <= i_pc;
      r_alu  <= i_alu;
      r_mem  <= i_mem;
      r_dest <= i_dest;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_pc   = r_pc;
  assign o_alu  = r_alu;
  assign o_mem  = r_mem;
  assign o_dest = r_dest;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
//------------------------------------------------------------------------------
// mem_access_stage : MIPS32 MEM stage, word load/store over req/ack with timeout
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_stage
  import mips32_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ctrl_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  dest_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [1:0]  wb_ctrl,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_mem,
  output logic [4:0]  wb_dest,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             r_kill;
  logic             r_mis;
  logic             r_berr;
  logic [31:0]      r_pc;
  logic [31:0]      r_alu;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [4:0]       r_dest;
  logic [1:0]       r_ctrl;

  logic        w_mem_op;
  logic        w_aligned;
  logic        w_idle;
  logic        w_busy;
  logic        w_done;
  logic        w_start;
  logic        w_mis;
  logic        w_wb_en;
  logic [1:0]  w_wb_ctrl;
  logic [31:0] w_wb_pc;
  logic [31:0] w_wb_alu;
  logic [31:0] w_wb_mem;
  logic [4:0]  w_wb_dest;

  assign w_mem_op  = ctrl_in[CTL_MEMREAD] | ctrl_in[CTL_MEMWRITE];
  assign w_aligned = (alu_in[1:0] == 2'b00);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_BUSY);
  assign w_done    = (r_state == ST_DONE);
  assign w_start   = w_idle & w_mem_op & w_aligned;
  assign w_mis     = w_idle & w_mem_op & ~w_aligned;

  assign stall      = ~rst & (w_start | w_busy);
  assign dmem_req   = w_busy;
  assign dmem_we    = w_busy & r_we;
  assign dmem_addr  = r_alu;
  assign dmem_wdata = r_wdata;

  assign misalign_exc = r_mis;
  assign bus_err      = r_berr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_kill  <= 1'b0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
      r_pc    <= 32'h0;
      r_alu   <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_dest  <= 5'd0;
      r_ctrl  <= 2'b00;
    end else begin
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_mis <= w_mis;
          if (w_start) begin
            r_state <= ST_BUSY;
            // memRead wins when both mem bits are set
            r_we    <= ~ctrl_in[CTL_MEMREAD];
            r_pc    <= pc_in;
            r_alu   <= alu_in;
            r_wdata <= rt_in;
            r_dest  <= dest_in;
            r_ctrl  <= {ctrl_in[CTL_REGWRITE], ctrl_in[CTL_MEMTOREG]};
            r_kill  <= 1'b0;
            r_rdata <= 32'h0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            if (!r_we) begin
              r_rdata <= dmem_rdata;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_kill  <= 1'b1;
            r_berr  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // DONE retires the latched instruction; IDLE passes non-mem ops and misaligned bubbles
  assign w_wb_en   = (w_idle & ~w_start) | w_done;
  assign w_wb_ctrl = w_done ? (r_kill ? 2'b00 : r_ctrl)
                            : (w_mis ? 2'b00 : {ctrl_in[CTL_REGWRITE], ctrl_in[CTL_MEMTOREG]});
  assign w_wb_pc   = w_done ? r_pc   : pc_in;
  assign w_wb_alu  = w_done ? r_alu  : alu_in;
  assign w_wb_mem  = w_done ? r_rdata : 32'h0;
  assign w_wb_dest = w_done ? r_dest : dest_in;

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_wb_en),
    .i_ctrl (w_wb_ctrl),
    .i_pc   (w_wb_pc),
    .i_alu  (w_wb_alu),
    .i_mem  (w_wb_mem),
    .i_dest (w_wb_dest),
    .o_ctrl (wb_ctrl),
    .o_pc   (wb_pc),
    .o_alu  (wb_alu),
    .o_mem  (wb_mem),
    .o_dest (wb_dest)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
//------------------------------------------------------------------------------
// tb_mem_access_stage : vector table plus handshake sequences, scoreboarded WB
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ctrl_in;
  logic [31:0] pc_in;
  logic [31:0] alu_in;
  logic [31:0] rt_in;
  logic [4:0]  dest_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  wb_ctrl;
  logic [31:0] wb_pc;
  logic [31:0] wb_alu;
  logic [31:0] wb_mem;
  logic [4:0]  wb_dest;
  logic        misalign_exc;
  logic        bus_err;

  mem_access_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_in      (ctrl_in),
    .pc_in        (pc_in),
    .alu_in       (alu_in),
    .rt_in        (rt_in),
    .dest_in      (dest_in),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_ctrl      (wb_ctrl),
    .wb_pc        (wb_pc),
    .wb_alu       (wb_alu),
    .wb_mem       (wb_mem),
    .wb_dest      (wb_dest),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
  } wb_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [1:0]  ectrl;
    logic        emis;
  } vec_t;

  wb_t  sb[$];
  wb_t  last;
  vec_t vt[7];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string nm);
    wb_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got %h want entry", nm, wb_alu);
    end else begin
      e    = sb.pop_front();
      last = e;
      chk({nm, ".wb_ctrl"}, 32'(wb_ctrl), 32'(e.ctrl));
      chk({nm, ".wb_pc"},   wb_pc,        e.pc);
      chk({nm, ".wb_alu"},  wb_alu,       e.alu);
      chk({nm, ".wb_mem"},  wb_mem,       e.mem);
      chk({nm, ".wb_dest"}, 32'(wb_dest), 32'(e.dest));
    end
  endtask

  task automatic apply_vec(input int i);
    wb_t e;
    ctrl_in    = vt[i].ctrl;
    pc_in      = vt[i].pc;
    alu_in     = vt[i].alu;
    rt_in      = 32'h1111_0000 + 32'(i);
    dest_in    = vt[i].dest;
    dmem_ack   = i[0];
    dmem_rdata = 32'hA5A5_0000 + 32'(i);
    #1;
    chk($sformatf("vec%0d.stall", i), 32'(stall), 32'd0);
    chk($sformatf("vec%0d.req", i), 32'(dmem_req), 32'd0);
    e.ctrl = vt[i].ectrl;
    e.pc   = vt[i].pc;
    e.alu  = vt[i].alu;
    e.mem  = 32'h0;
    e.dest = vt[i].dest;
    sb.push_back(e);
    tick();
    dmem_ack = 1'b0;
    pop_cmp($sformatf("vec%0d", i));
    chk($sformatf("vec%0d.misalign", i), 32'(misalign_exc), 32'(vt[i].emis));
    chk($sformatf("vec%0d.bus_err", i), 32'(bus_err), 32'd0);
  endtask

  // ack_at: BUSY cycle (1-based) carrying dmem_ack, 0 means never ack
  task automatic mem_txn(input string nm, input logic [3:0] c, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] rt, input logic [4:0] d,
                         input int ack_at, input logic [31:0] rd);
    int   nbusy;
    int   stalls;
    logic rd_op;
    wb_t  e;
    nbusy = (ack_at == 0) ? TO : ack_at;
    rd_op = c[3];
    ctrl_in = c; pc_in = pc; alu_in = a; rt_in = rt; dest_in = d; dmem_ack = 1'b0;
    #1;
    stalls = int'(stall);
    chk({nm, ".idle_req"}, 32'(dmem_req), 32'd0);
    e.ctrl = (ack_at == 0) ? 2'b00 : c[1:0];
    e.pc   = pc;
    e.alu  = a;
    e.mem  = (ack_at != 0 && rd_op) ? rd : 32'h0;
    e.dest = d;
    sb.push_back(e);
    tick();
    for (int k = 1; k <= nbusy; k++) begin
      chk($sformatf("%s.busy%0d.req", nm, k), 32'(dmem_req), 32'd1);
      chk($sformatf("%s.busy%0d.addr", nm, k), dmem_addr, a);
      chk($sformatf("%s.busy%0d.we", nm, k), 32'(dmem_we), 32'(!rd_op));
      if (!rd_op) chk($sformatf("%s.busy%0d.wdata", nm, k), dmem_wdata, rt);
      if (k == 1) chk({nm, ".hold_alu"}, wb_alu, last.alu);
      stalls += int'(stall);
      if (k == ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
      end
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
    end
    stalls += int'(stall);
    chk({nm, ".done_req"}, 32'(dmem_req), 32'd0);
    chk({nm, ".bus_err"}, 32'(bus_err), 32'(ack_at == 0));
    chk({nm, ".stall_cycles"}, 32'(stalls), 32'(1 + nbusy));
    if (ack_at == 0) begin
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
    end
    tick();
    dmem_ack = 1'b0;
    pop_cmp(nm);
    chk({nm, ".bus_err_clr"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b0010, 32'h0000_0400, 32'h0000_1234, 5'd5,  2'b10, 1'b0};
    vt[1] = '{4'b0011, 32'h0000_0404, 32'h8000_0001, 5'd7,  2'b11, 1'b0};
    vt[2] = '{4'b0000, 32'h0000_0408, 32'h0F0F_0F0F, 5'd0,  2'b00, 1'b0};
    vt[3] = '{4'b1011, 32'h0000_040C, 32'h0000_0102, 5'd9,  2'b00, 1'b1};
    vt[4] = '{4'b0100, 32'h0000_0410, 32'h0000_0203, 5'd3,  2'b00, 1'b1};
    vt[5] = '{4'b1110, 32'h0000_0414, 32'h0000_0001, 5'd12, 2'b00, 1'b1};
    vt[6] = '{4'b0010, 32'h0000_0418, 32'hFFFF_FFFF, 5'd31, 2'b10, 1'b0};
    last  = '{2'b00, 32'h0, 32'h0, 32'h0, 5'd0};

    rst = 1'b1;
    ctrl_in = 4'b1010; pc_in = 32'h0; alu_in = 32'h100; rt_in = 32'h0; dest_in = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall",   32'(stall),        32'd0);
    chk("rst.req",     32'(dmem_req),     32'd0);
    chk("rst.wb_ctrl", 32'(wb_ctrl),      32'd0);
    chk("rst.wb_alu",  wb_alu,            32'd0);
    chk("rst.mis",     32'(misalign_exc), 32'd0);
    chk("rst.berr",    32'(bus_err),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply_vec(i);

    mem_txn("load_ack2",  4'b1011, 32'h500, 32'h100, 32'h0,         5'd4,  2, 32'hDEAD_BEEF);
    mem_txn("store_ack1", 4'b0100, 32'h504, 32'h200, 32'hCAFE_F00D, 5'd6,  1, 32'h7777_7777);
    mem_txn("both_read",  4'b1110, 32'h508, 32'h280, 32'h1357_9BDF, 5'd8,  1, 32'h2468_ACE0);
    mem_txn("timeout",    4'b1011, 32'h50C, 32'h300, 32'h0,         5'd10, 0, 32'h0);
    apply_vec(0);

    ctrl_in = 4'b1011; pc_in = 32'h600; alu_in = 32'h440; dest_in = 5'd2;
    tick();
    chk("rst_mid.req_before", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid.req",     32'(dmem_req), 32'd0);
    chk("rst_mid.stall",   32'(stall),    32'd0);
    chk("rst_mid.wb_ctrl", 32'(wb_ctrl),  32'd0);
    chk("rst_mid.wb_alu",  wb_alu,        32'd0);
    chk("rst_mid.wb_pc",   wb_pc,         32'd0);
    sb.delete();
    last = '{2'b00, 32'h0, 32'h0, 32'h0, 5'd0};
    @(negedge clk);
    rst = 1'b0;
    mem_txn("load_after_rst", 4'b1011, 32'h604, 32'h500, 32'h0, 5'd11, 1, 32'h1234_5678);

    ctrl_in = 4'b0000;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
